// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: W stage has priority, secondary writes queue in a FIFO,
// and a starvation counter periodically forces the FIFO head through by stalling W.
module rf_wport_arbiter #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_we,
   input  logic [4:0]  p_a3,
   input  logic [31:0] p_wd,
   input  logic [31:0] p_pc,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [4:0]  s_a3,
   input  logic [31:0] s_wd,
   input  logic [31:0] s_pc,
   output logic        stall_w,
   output logic        RegWE,
   output logic [4:0]  A3,
   output logic [31:0] RWD,
   output logic [31:0] WPC,
   input  logic [4:0]  q1_a,
   input  logic [4:0]  q2_a,
   output logic        q1_hit,
   output logic        q2_hit
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [4:0]    r_a3 [DEPTH];
   logic [31:0]   r_wd [DEPTH];
   logic [31:0]   r_pc [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starve;

   logic          w_pwe;
   logic          w_nonempty;
   logic          w_force;
   logic          w_grant_head;
   logic          w_grant_p;
   logic          w_push;
   logic [AW-1:0] w_idx;

   assign w_pwe        = p_we && (p_a3 != 5'd0);
   assign w_nonempty   = (r_count != '0);
   assign w_force      = w_nonempty && w_pwe && (r_starve == SW'(STARVE_MAX));
   assign w_grant_head = reset && w_nonempty && (!w_pwe || w_force);
   assign w_grant_p    = reset && w_pwe && !w_grant_head;
   assign stall_w      = reset && w_force;
   assign s_ready      = reset && (r_count < CW'(DEPTH));
   // Writes to $0 are accepted to keep the handshake flowing but never stored.
   assign w_push       = s_valid && s_ready && (s_a3 != 5'd0);

   always_comb begin
      RegWE = 1'b0;
      A3    = '0;
      RWD   = '0;
      WPC   = '0;
      if (w_grant_head) begin
         RegWE = 1'b1;
         A3    = r_a3[r_head];
         RWD   = r_wd[r_head];
         WPC   = r_pc[r_head];
      end else if (w_grant_p) begin
         RegWE = 1'b1;
         A3    = p_a3;
         RWD   = p_wd;
         WPC   = p_pc;
      end
   end

   // Only the count entries starting at head are live; stale slots must not hit.
   always_comb begin
      q1_hit = 1'b0;
      q2_hit = 1'b0;
      w_idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_idx = r_head + AW'(i);
         if (reset && (i < 32'(r_count))) begin
            if ((q1_a != 5'd0) && (r_a3[w_idx] == q1_a)) q1_hit = 1'b1;
            if ((q2_a != 5'd0) && (r_a3[w_idx] == q2_a)) q2_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_a3[r_tail] <= s_a3;
         r_wd[r_tail] <= s_wd;
         r_pc[r_tail] <= s_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_starve <= '0;
      end else begin
         if (w_push)       r_tail <= r_tail + AW'(1);
         if (w_grant_head) r_head <= r_head + AW'(1);
         if (w_push && !w_grant_head)      r_count <= r_count + CW'(1);
         else if (!w_push && w_grant_head) r_count <= r_count - CW'(1);
         if (w_nonempty && w_pwe && (r_starve < SW'(STARVE_MAX)))
            r_starve <= r_starve + SW'(1);
         else
            r_starve <= '0;
      end
   end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4) with hand-computed expectations.
module tb_rf_wport_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_we;
   logic [4:0]  p_a3;
   logic [31:0] p_wd;
   logic [31:0] p_pc;
   logic        s_valid;
   logic        s_ready;
   logic [4:0]  s_a3;
   logic [31:0] s_wd;
   logic [31:0] s_pc;
   logic        stall_w;
   logic        RegWE;
   logic [4:0]  A3;
   logic [31:0] RWD;
   logic [31:0] WPC;
   logic [4:0]  q1_a;
   logic [4:0]  q2_a;
   logic        q1_hit;
   logic        q2_hit;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
      .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
      .stall_w(stall_w), .RegWE(RegWE), .A3(A3), .RWD(RWD), .WPC(WPC),
      .q1_a(q1_a), .q2_a(q2_a), .q1_hit(q1_hit), .q2_hit(q2_hit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one clock, then let new inputs settle before checking.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic chk_port(input string tag, input logic we, input logic [4:0] a3,
                           input logic [31:0] wd, input logic [31:0] pc, input logic st);
      chk({tag, ".RegWE"}, RegWE, we);
      chk({tag, ".A3"}, A3, a3);
      chk({tag, ".RWD"}, RWD, wd);
      chk({tag, ".WPC"}, WPC, pc);
      chk({tag, ".stall"}, stall_w, st);
   endtask

   initial begin
      reset = 1'b0; p_we = 1'b1; p_a3 = 5'd5; p_wd = 32'h1234; p_pc = 32'h100;
      s_valid = 1'b1; s_a3 = 5'd7; s_wd = 32'h0; s_pc = 32'h0; q1_a = 5'd7; q2_a = 5'd5;
      #1; settle();
      chk("rst.s_ready", s_ready, 1'b0);
      chk_port("rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      chk("rst.q1_hit", q1_hit, 1'b0);
      chk("rst.q2_hit", q2_hit, 1'b0);

      // Uncontested primary
      tick();
      reset = 1'b1; s_valid = 1'b0;
      settle();
      chk_port("prim", 1'b1, 5'd5, 32'h1234, 32'h100, 1'b0);
      chk("prim.s_ready", s_ready, 1'b1);

      // Uncontested secondary: grant one cycle after acceptance
      tick();
      p_we = 1'b0; s_valid = 1'b1; s_a3 = 5'd8; s_wd = 32'hAA; s_pc = 32'h200; q1_a = 5'd8;
      settle();
      chk_port("sec0", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      chk("sec0.q1_hit", q1_hit, 1'b0);
      tick();
      s_valid = 1'b0;
      settle();
      chk_port("sec1", 1'b1, 5'd8, 32'hAA, 32'h200, 1'b0);
      chk("sec1.q1_hit", q1_hit, 1'b1);
      tick();
      settle();
      chk_port("sec2", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      chk("sec2.q1_hit", q1_hit, 1'b0);

      // $0 handling on both sources
      tick();
      p_we = 1'b1; p_a3 = 5'd0; p_wd = 32'h55; s_valid = 1'b1; s_a3 = 5'd0; s_wd = 32'h77;
      q1_a = 5'd0;
      settle();
      chk_port("zero0", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      chk("zero0.s_ready", s_ready, 1'b1);
      chk("zero0.q1_hit", q1_hit, 1'b0);
      tick();
      p_we = 1'b0; s_valid = 1'b0;
      settle();
      chk_port("zero1", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      chk("zero1.q1_hit", q1_hit, 1'b0);

      // Fill, back-pressure and starvation with continuous primary traffic
      tick();
      p_we = 1'b1; p_a3 = 5'd3; p_wd = 32'hF00D; p_pc = 32'h300;
      s_valid = 1'b1; s_a3 = 5'd9; s_wd = 32'hA1; s_pc = 32'h400; q1_a = 5'd9; q2_a = 5'd10;
      settle();
      chk_port("c0", 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      chk("c0.s_ready", s_ready, 1'b1);
      tick();
      s_a3 = 5'd10; s_wd = 32'hB2; s_pc = 32'h404;
      settle();
      chk_port("c1", 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      chk("c1.s_ready", s_ready, 1'b1);
      chk("c1.q1_hit", q1_hit, 1'b1);
      chk("c1.q2_hit", q2_hit, 1'b0);
      tick();
      s_a3 = 5'd11; s_wd = 32'hC3; s_pc = 32'h408;
      settle();
      chk_port("c2", 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      chk("c2.s_ready", s_ready, 1'b0);
      chk("c2.q2_hit", q2_hit, 1'b1);
      for (int k = 3; k <= 4; k++) begin
         tick();
         settle();
         chk_port($sformatf("c%0d", k), 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
         chk($sformatf("c%0d.s_ready", k), s_ready, 1'b0);
      end
      tick();
      settle();
      chk_port("c5.forceA", 1'b1, 5'd9, 32'hA1, 32'h400, 1'b1);
      chk("c5.s_ready", s_ready, 1'b0);
      tick();
      settle();
      chk_port("c6.held", 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      chk("c6.s_ready", s_ready, 1'b1);
      chk("c6.q1_hit", q1_hit, 1'b0);
      tick();
      s_valid = 1'b0; q1_a = 5'd11;
      settle();
      chk("c7.q1_hit", q1_hit, 1'b1);
      for (int k = 7; k <= 9; k++) begin
         if (k != 7) begin
            tick();
            settle();
         end
         chk_port($sformatf("c%0d", k), 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      end
      tick();
      settle();
      chk_port("c10.forceB", 1'b1, 5'd10, 32'hB2, 32'h404, 1'b1);
      for (int k = 11; k <= 14; k++) begin
         tick();
         settle();
         chk_port($sformatf("c%0d", k), 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      end
      tick();
      settle();
      chk_port("c15.forceC", 1'b1, 5'd11, 32'hC3, 32'h408, 1'b1);
      tick();
      settle();
      chk_port("c16.held", 1'b1, 5'd3, 32'hF00D, 32'h300, 1'b0);
      chk("c16.q1_hit", q1_hit, 1'b0);
      tick();
      p_we = 1'b0;
      settle();
      chk_port("c17.idle", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);

      // Reset mid-operation discards queued entries
      tick();
      p_we = 1'b1; s_valid = 1'b1; s_a3 = 5'd12; s_wd = 32'hD4; s_pc = 32'h500;
      q1_a = 5'd12; q2_a = 5'd13;
      tick();
      s_a3 = 5'd13; s_wd = 32'hE5; s_pc = 32'h504;
      settle();
      chk("r1.q1_hit", q1_hit, 1'b1);
      tick();
      reset = 1'b0; s_a3 = 5'd14;
      settle();
      chk("r2.s_ready", s_ready, 1'b0);
      chk_port("r2", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      chk("r2.q1_hit", q1_hit, 1'b0);
      tick();
      reset = 1'b1; p_we = 1'b0; s_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) tick();
         settle();
         chk_port($sformatf("r%0d.after", k + 3), 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
         chk($sformatf("r%0d.q1_hit", k + 3), q1_hit, 1'b0);
         chk($sformatf("r%0d.q2_hit", k + 3), q2_hit, 1'b0);
         chk($sformatf("r%0d.s_ready", k + 3), s_ready, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
